riscv_trace_monitor: RTL

- Synthesizable, parametrised observation block that sits beside the miniRISC core and watches its result buses (out1/out2 and future channels).
- After a start pulse, records every change on any channel, with a cycle timestamp, into a FIFO trace buffer.
- Detects program completion (all channels quiet for a set number of cycles) and runaway (timeout).
- Replaces the fixed "run 1000 ns then stop" bring-up with a self-timed monitor that can also be read out on FPGA.

---
 rtl/riscv_trace_monitor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/riscv_trace_monitor.sv
// Trace monitor for the miniRISC result buses.
// After a start pulse it timestamps every change on the observed channels into a
// first-word-fall-through buffer. It ends in DONE when the channels stay quiet,
// or in TIMEOUT when the run budget is used up.
module riscv_trace_monitor #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned STABLE_CYC = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH*DATA_W-1:0]          ch_data,
  input  logic                              start,
  input  logic                              rd_ready,
  output logic                              rd_valid,
  output logic [CNT_W+NUM_CH*DATA_W-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              busy,
  output logic                              done,
  output logic                              timed_out,
  output logic                              overflow
);

  localparam int unsigned CH_W    = NUM_CH * DATA_W;
  localparam int unsigned ENTRY_W = CNT_W + CH_W;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ST_W    = $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [ST_W-1:0]    stable_cnt;
  logic               seen_change;
  logic [CH_W-1:0]    prev;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic restart;
  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Event decode: restart, change detection and buffer handshakes
  always_comb begin
    restart = start && (state != S_RUN);
    change  = (state == S_RUN) && (ch_data != prev);
    full    = (count == (PTR_W+1)'(DEPTH));
    // A restart flushes the buffer, so a pop in that same cycle is discarded
    pop     = rd_valid && rd_ready && !restart;
    // When full, a simultaneous pop frees the slot the push needs
    push    = change && (!full || pop);
    drop    = change && full && !pop;
  end

  // Next-state logic; the timeout check takes priority over completion
  always_comb begin
    state_next = state;
    case (state)
      S_RUN: begin
        if (cycle_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_next = S_TIMEOUT;
        end else if (seen_change && !change && (stable_cnt == ST_W'(STABLE_CYC - 1))) begin
          state_next = S_DONE;
        end
      end
      default: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run counters, change reference and completion tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      stable_cnt  <= '0;
      seen_change <= 1'b0;
      prev        <= '0;
    end else if (restart) begin
      cycle_cnt   <= '0;
      stable_cnt  <= '0;
      seen_change <= 1'b0;
      prev        <= ch_data;
    end else if (state == S_RUN) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (change) begin
        prev        <= ch_data;
        stable_cnt  <= '0;
        seen_change <= 1'b1;
      end else if (stable_cnt != ST_W'(STABLE_CYC)) begin
        stable_cnt <= stable_cnt + ST_W'(1);
      end
    end
  end

  // Buffer pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (restart) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Trace storage; entries carry the timestamp of the cycle the change was sampled in
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cycle_cnt, ch_data};
    end
  end

  // Status and fall-through read port
  always_comb begin
    rd_valid  = (count != '0);
    rd_data   = mem[rd_ptr];
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    timed_out = (state == S_TIMEOUT);
  end

endmodule
